perf_counter_unit: RTL and testbench
====================================

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 Parameter BASE_ADDRESS, default 0, byte address of register block; 4 KB aligned.
REQ-002 Parameter NUM_EVENTS, default 1, number of event inputs; range 1..256.
REQ-003 Parameter NUM_COUNTERS, default 4, number of counters; range 1..32.
REQ-004 Parameter COUNTER_WIDTH, default 48, counter width in bits; range 33..64.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 perf_events  input  NUM_EVENTS  one level-sampled event flag per bit, sampled every cycle.
REQ-008 io_write_en  input  1  register write strobe, single cycle.
REQ-009 io_read_en  input  1  register read strobe, single cycle.
REQ-010 io_address  input  32  byte address, word aligned.
REQ-011 io_write_data  input  32  write data.
REQ-012 io_read_data  output  32  read data, valid the cycle after io_read_en.
REQ-013 perf_irq  output  1  level interrupt, overflow pending and enabled.

Function
REQ-014 Counter i registers SHALL sit at BASE_ADDRESS + 16*i: +0 SELECT (R/W), +4 COUNT_LO (R/W), +8 COUNT_HI (R/W), +12 reserved (reads 0).
REQ-015 Global registers SHALL sit at BASE_ADDRESS + 0x400 ENABLE (R/W, bit i = counter i), +0x404 OVERFLOW (R, write-1-to-clear), +0x408 IRQ_ENABLE (R/W).
REQ-016 SELECT SHALL hold bits [7:0] event index and bit [16] edge mode; other bits SHALL read 0.
REQ-017 Counter i SHALL increment by 1 in a cycle only when ENABLE[i] is 1 and its selected event qualifies.
REQ-018 Level mode qualification: perf_events[index] is 1 this cycle.
REQ-019 Edge mode qualification: perf_events[index] is 1 this cycle and was 0 the previous cycle, using a per-counter history register.
REQ-020 Event index >= NUM_EVENTS SHALL never qualify; the counter holds.
REQ-021 Writing SELECT SHALL clear that counter's edge history to 0.
REQ-022 Arithmetic modulo 2^COUNTER_WIDTH; an increment from all-ones SHALL yield 0 and set OVERFLOW[i] in the same edge.
REQ-023 Writing COUNT_LO SHALL load bits [31:0] from io_write_data and leave upper bits unchanged; writing COUNT_HI SHALL load bits [COUNTER_WIDTH-1:32] from io_write_data low bits, leaving bits [31:0] unchanged.
REQ-024 A counter write and a qualifying event in the same cycle: the write SHALL win; no increment, no overflow.
REQ-025 OVERFLOW set and write-1-to-clear of the same bit in the same cycle: set SHALL win.
REQ-026 Reading COUNT_LO SHALL return bits [31:0] and latch bits [COUNTER_WIDTH-1:32] into a single shared shadow register, both from the same cycle.
REQ-027 Reading COUNT_HI SHALL return the shadow, zero-extended, not the live upper bits.
REQ-028 Read latency SHALL be exactly one cycle; io_read_data SHALL hold its value until the next read.
REQ-029 Unmapped addresses and counters >= NUM_COUNTERS SHALL read 0; writes to them SHALL be ignored.
REQ-030 perf_irq SHALL equal the registered OR of (OVERFLOW & IRQ_ENABLE), updating one cycle after the underlying bits change.
REQ-031 Simultaneous read and write to the same register: the read SHALL return the pre-write value.

Reset
REQ-032 Reset SHALL clear all counters, SELECT, ENABLE, OVERFLOW, IRQ_ENABLE, edge history, shadow, io_read_data and perf_irq to 0, taking effect immediately.
REQ-033 Reset asserted mid-count SHALL discard any increment or register write pending in that cycle.

Verification
REQ-034 ENABLE=1, SELECT0=0, perf_events[0] high 10 cycles -> COUNT_LO of counter 0 reads 10.
REQ-035 SELECT0 edge mode, perf_events[0] pattern 1,1,0,1,0,1 -> count 3.
REQ-036 COUNT_LO=0xFFFFFFFF, COUNT_HI=0xFFFF (width 48), one event, IRQ_ENABLE=1 -> count 0, OVERFLOW[0]=1, perf_irq=1 next cycle; W1C 1 -> perf_irq=0.
REQ-037 Counter at 0x0_FFFFFFFF: read LO, then event increments, then read HI -> LO=0xFFFFFFFF, HI=0 (shadow, not live 1).
REQ-038 COUNT_LO write coincides with qualifying event -> counter equals written value; SELECT=NUM_EVENTS -> counter never moves.
REQ-039 Reset pulse mid-count with perf_irq high -> all registers read 0 and perf_irq=0 immediately.

Source files
------------

// File: rtl/perf_counter_unit_if.sv
// Register-bus interface of the performance counter unit.
// master drives strobes/address/data, slave returns registered read data.
interface perf_counter_unit_if;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;

  modport master (
    output io_write_en,
    output io_read_en,
    output io_address,
    output io_write_data,
    input  io_read_data
  );

  modport slave (
    input  io_write_en,
    input  io_read_en,
    input  io_address,
    input  io_write_data,
    output io_read_data
  );
endinterface

// File: rtl/perf_counter_unit.sv
// Performance counter unit: NUM_COUNTERS event counters, each selecting one
// event input in level or rising-edge mode. The counters sit behind a small
// memory-mapped register block with overflow flags, an interrupt enable, and a
// shared shadow register that makes LO-then-HI reads consistent.
module perf_counter_unit #(
  parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0000,
  parameter int          NUM_EVENTS    = 1,
  parameter int          NUM_COUNTERS  = 4,
  parameter int          COUNTER_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] perf_events,
  perf_counter_unit_if.slave    bus,
  output logic                  perf_irq
);

  localparam int HW = COUNTER_WIDTH - 32;

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;

  // Architectural state
  cnt_t                    cnt_r     [NUM_COUNTERS];
  logic [7:0]              sel_idx_r [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] sel_edge_r;
  logic [NUM_COUNTERS-1:0] hist_r;
  logic [NUM_COUNTERS-1:0] enable_r;
  logic [NUM_COUNTERS-1:0] ovf_r;
  logic [NUM_COUNTERS-1:0] irq_en_r;
  logic [HW-1:0]           shadow_r;
  logic [31:0]             rdata_r;
  logic                    irq_r;

  // Address decode
  logic                    in_block_s;
  logic [5:0]              cidx_s;
  logic [1:0]              creg_s;
  logic                    is_cnt_s;
  logic                    is_en_s;
  logic                    is_ovf_s;
  logic                    is_irqen_s;
  logic [NUM_COUNTERS-1:0] hit_s;

  // Per-counter control
  logic [255:0]            ev_pad_s;
  logic [NUM_COUNTERS-1:0] ev_s;
  logic [NUM_COUNTERS-1:0] qual_s;
  logic [NUM_COUNTERS-1:0] inc_s;
  logic [NUM_COUNTERS-1:0] wrap_s;
  logic [NUM_COUNTERS-1:0] wr_sel_s;
  logic [NUM_COUNTERS-1:0] wr_lo_s;
  logic [NUM_COUNTERS-1:0] wr_hi_s;
  logic [NUM_COUNTERS-1:0] w1c_s;

  // Read path
  logic [31:0]             rd_val_s;
  logic                    shadow_ld_s;
  logic [HW-1:0]           shadow_val_s;

  // Byte-lane bits of the address carry no information for word registers
  logic                    unused_addr_s;
  assign unused_addr_s = ^bus.io_address[1:0];

  // Decode the bus address into a counter hit or one of the global registers
  always_comb begin
    in_block_s = (bus.io_address[31:12] == BASE_ADDRESS[31:12]);
    cidx_s     = bus.io_address[9:4];
    creg_s     = bus.io_address[3:2];
    is_cnt_s   = in_block_s && (bus.io_address[11:10] == 2'b00);
    is_en_s    = in_block_s && (bus.io_address[11:2] == 10'h100);
    is_ovf_s   = in_block_s && (bus.io_address[11:2] == 10'h101);
    is_irqen_s = in_block_s && (bus.io_address[11:2] == 10'h102);
    hit_s      = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      hit_s[i] = is_cnt_s && (cidx_s == 6'(i));
    end
  end

  // Qualify events and resolve write-versus-increment per counter
  always_comb begin
    // Zero padding makes any index >= NUM_EVENTS select a constant 0
    ev_pad_s                   = '0;
    ev_pad_s[NUM_EVENTS-1:0]   = perf_events;
    wr_sel_s = '0;
    wr_lo_s  = '0;
    wr_hi_s  = '0;
    ev_s     = '0;
    qual_s   = '0;
    inc_s    = '0;
    wrap_s   = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      wr_sel_s[i] = bus.io_write_en && hit_s[i] && (creg_s == 2'd0);
      wr_lo_s[i]  = bus.io_write_en && hit_s[i] && (creg_s == 2'd1);
      wr_hi_s[i]  = bus.io_write_en && hit_s[i] && (creg_s == 2'd2);
      ev_s[i]     = ev_pad_s[sel_idx_r[i]];
      qual_s[i]   = sel_edge_r[i] ? (ev_s[i] && !hist_r[i]) : ev_s[i];
      // A software write to the count suppresses the increment
      inc_s[i]    = enable_r[i] && qual_s[i] && !wr_lo_s[i] && !wr_hi_s[i];
      wrap_s[i]   = inc_s[i] && (cnt_r[i] == '1);
    end
    w1c_s = (bus.io_write_en && is_ovf_s) ? bus.io_write_data[NUM_COUNTERS-1:0] : '0;
  end

  // Select the read value from current (pre-write) register contents
  always_comb begin
    rd_val_s     = 32'h0;
    shadow_ld_s  = 1'b0;
    shadow_val_s = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (hit_s[i]) begin
        case (creg_s)
          2'd0: rd_val_s = {15'h0, sel_edge_r[i], 8'h0, sel_idx_r[i]};
          2'd1: begin
            rd_val_s     = cnt_r[i][31:0];
            shadow_ld_s  = bus.io_read_en;
            shadow_val_s = cnt_r[i][COUNTER_WIDTH-1:32];
          end
          2'd2:    rd_val_s = 32'(shadow_r);
          default: rd_val_s = 32'h0;
        endcase
      end else begin
        rd_val_s = rd_val_s;
      end
    end
    if (is_en_s) begin
      rd_val_s = 32'(enable_r);
    end else if (is_ovf_s) begin
      rd_val_s = 32'(ovf_r);
    end else if (is_irqen_s) begin
      rd_val_s = 32'(irq_en_r);
    end else begin
      rd_val_s = rd_val_s;
    end
  end

  // Counter values, event selection and per-counter edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_r[i]     <= '0;
        sel_idx_r[i] <= 8'h0;
      end
      sel_edge_r <= '0;
      hist_r     <= '0;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (wr_lo_s[i]) begin
          cnt_r[i][31:0] <= bus.io_write_data;
        end else if (wr_hi_s[i]) begin
          cnt_r[i][COUNTER_WIDTH-1:32] <= bus.io_write_data[HW-1:0];
        end else if (inc_s[i]) begin
          cnt_r[i] <= cnt_r[i] + cnt_t'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
        if (wr_sel_s[i]) begin
          sel_idx_r[i]  <= bus.io_write_data[7:0];
          sel_edge_r[i] <= bus.io_write_data[16];
          hist_r[i]     <= 1'b0;
        end else begin
          hist_r[i] <= ev_s[i];
        end
      end
    end
  end

  // Global enable, overflow (set beats clear) and interrupt state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_r <= '0;
      irq_en_r <= '0;
      ovf_r    <= '0;
      irq_r    <= 1'b0;
    end else begin
      if (bus.io_write_en && is_en_s) begin
        enable_r <= bus.io_write_data[NUM_COUNTERS-1:0];
      end
      if (bus.io_write_en && is_irqen_s) begin
        irq_en_r <= bus.io_write_data[NUM_COUNTERS-1:0];
      end
      ovf_r <= (ovf_r & ~w1c_s) | wrap_s;
      irq_r <= |(ovf_r & irq_en_r);
    end
  end

  // Registered read data held between reads, and the HI shadow latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r  <= 32'h0;
      shadow_r <= '0;
    end else begin
      if (bus.io_read_en) begin
        rdata_r <= rd_val_s;
      end
      if (shadow_ld_s) begin
        shadow_r <= shadow_val_s;
      end
    end
  end

  assign bus.io_read_data = rdata_r;
  assign perf_irq         = irq_r;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench for perf_counter_unit: a driver pushes expected read data and
// interrupt levels from a behavioural model; a monitor pops and compares.
module tb_perf_counter_unit;
  localparam logic [31:0]     BASE  = 32'h0000_3000;
  localparam int              NE    = 4;
  localparam int              NC    = 4;
  localparam int              CW    = 48;
  localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;

  logic          clk = 1'b0;
  logic          reset;
  logic [NE-1:0] perf_events;
  logic          perf_irq;

  perf_counter_unit_if bus ();

  perf_counter_unit #(
    .BASE_ADDRESS (BASE),
    .NUM_EVENTS   (NE),
    .NUM_COUNTERS (NC),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .perf_events(perf_events),
    .bus        (bus),
    .perf_irq   (perf_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t rd_q[$];
  bit   irq_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_rd;

  // Behavioural model state
  longint unsigned m_cnt  [NC];
  int              m_idx  [NC];
  bit              m_edge [NC];
  bit              m_hist [NC];
  bit [NC-1:0]     m_en, m_ovf, m_irqen;
  longint unsigned m_shadow;

  localparam logic [31:0] G_EN  = BASE + 32'h400;
  localparam logic [31:0] G_OVF = BASE + 32'h404;
  localparam logic [31:0] G_IRQ = BASE + 32'h408;

  function automatic logic [31:0] ca(int i, int r);
    return BASE + 32'(i * 16 + r * 4);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0; m_idx[i] = 0; m_edge[i] = 0; m_hist[i] = 0;
    end
    m_en = '0; m_ovf = '0; m_irqen = '0; m_shadow = 0;
  endtask

  function automatic logic [31:0] m_read(logic [31:0] addr);
    logic [31:0] off;
    int i;
    if (addr < BASE || addr >= BASE + 32'h1000) return 32'h0;
    off = addr - BASE;
    if (off < 32'h400) begin
      i = int'(off >> 4);
      if (i >= NC) return 32'h0;
      case (off[3:2])
        2'd0:    return (32'(m_edge[i]) << 16) | 32'(m_idx[i]);
        2'd1:    return 32'(m_cnt[i] & 64'hFFFF_FFFF);
        2'd2:    return 32'(m_shadow);
        default: return 32'h0;
      endcase
    end
    if (off == 32'h400) return 32'(m_en);
    if (off == 32'h404) return 32'(m_ovf);
    if (off == 32'h408) return 32'(m_irqen);
    return 32'h0;
  endfunction

  // Advance the model by one clock edge for the given bus/event inputs
  task automatic model_step(bit we, bit re, logic [31:0] addr, logic [31:0] wd,
                            logic [NE-1:0] ev, bit use_const, logic [31:0] cexp, string nm);
    exp_t        e;
    logic [31:0] off;
    int          ci, cr;
    bit          inb;
    bit [NC-1:0] setm, w1c;
    if (re) begin
      e.name = nm;
      e.val  = use_const ? cexp : m_read(addr);
      rd_q.push_back(e);
    end
    irq_q.push_back(|(m_ovf & m_irqen));
    inb = (addr >= BASE) && (addr < BASE + 32'h1000);
    off = addr - BASE;
    ci  = int'(off >> 4);
    cr  = int'(off[3:2]);
    if (re && inb && off < 32'h400 && ci < NC && cr == 1) m_shadow = m_cnt[ci] >> 32;
    setm = '0;
    w1c  = '0;
    for (int i = 0; i < NC; i++) begin
      bit e_now, q, hit;
      hit   = we && inb && (off < 32'h400) && (ci == i);
      e_now = (m_idx[i] < NE) ? ev[m_idx[i]] : 1'b0;
      q     = m_edge[i] ? (e_now && !m_hist[i]) : e_now;
      if (hit && cr == 1) m_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | 64'(wd);
      else if (hit && cr == 2) m_cnt[i] = (m_cnt[i] & 64'hFFFF_FFFF) | ((64'(wd) << 32) & CMASK);
      else if (m_en[i] && q) begin
        m_cnt[i] = (m_cnt[i] + 1) & CMASK;
        if (m_cnt[i] == 0) setm[i] = 1'b1;
      end
      if (hit && cr == 0) begin
        m_idx[i] = int'(wd[7:0]); m_edge[i] = wd[16]; m_hist[i] = 1'b0;
      end else begin
        m_hist[i] = e_now;
      end
    end
    if (we && inb && off == 32'h404) w1c = wd[NC-1:0];
    m_ovf = (m_ovf & ~w1c) | setm;
    if (we && inb && off == 32'h400) m_en = wd[NC-1:0];
    if (we && inb && off == 32'h408) m_irqen = wd[NC-1:0];
  endtask

  task automatic cycle(bit we, bit re, logic [31:0] addr, logic [31:0] wd, logic [NE-1:0] ev,
                       bit use_const = 1'b0, logic [31:0] cexp = 32'h0, string nm = "rd_model");
    @(negedge clk);
    bus.io_write_en   = we;
    bus.io_read_en    = re;
    bus.io_address    = addr;
    bus.io_write_data = wd;
    perf_events       = ev;
    model_step(we, re, addr, wd, ev, use_const, cexp, nm);
    @(posedge clk);
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [NE-1:0] ev = '0);
    cycle(1'b1, 1'b0, a, d, ev);
  endtask

  task automatic rd_c(logic [31:0] a, logic [31:0] exp, string nm);
    cycle(1'b0, 1'b1, a, 32'h0, '0, 1'b1, exp, nm);
  endtask

  task automatic idle(int n, logic [NE-1:0] ev = '0);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, BASE, 32'h0, ev);
  endtask

  // Monitor: compare read data the cycle after each read, and the irq level every cycle
  always @(posedge clk) begin
    mon_rd = bus.io_read_en && !reset;
    #1;
    if (mon_rd) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_q_underflow: got read data %h with no expectation", bus.io_read_data);
      end else begin
        exp_t e;
        e = rd_q.pop_front();
        check(e.name, bus.io_read_data, e.val);
      end
    end
    if (irq_q.size() > 0) check("perf_irq", 32'(perf_irq), 32'(irq_q.pop_front()));
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.io_write_en = 1'b0; bus.io_read_en = 1'b0;
    bus.io_address = 32'h0; bus.io_write_data = 32'h0;
    perf_events = '0;
    model_reset();
    #12;
    check("reset_irq", 32'(perf_irq), 32'h0);
    check("reset_rdata", bus.io_read_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd_c(ca(0, 1), 32'h0, "reset_lo0");
    rd_c(G_EN, 32'h0, "reset_en");

    // Level mode, ten qualifying cycles
    wr(ca(0, 0), 32'h0);
    wr(G_EN, 32'h1);
    idle(10, 4'b0001);
    rd_c(ca(0, 1), 32'd10, "level_count10");

    // Edge mode, pattern 1,1,0,1,0,1
    wr(ca(0, 1), 32'h0);
    wr(ca(0, 0), 32'h0001_0000);
    idle(1, 4'b0001); idle(1, 4'b0001); idle(1, 4'b0000);
    idle(1, 4'b0001); idle(1, 4'b0000); idle(1, 4'b0001);
    rd_c(ca(0, 1), 32'd3, "edge_count3");
    rd_c(ca(0, 0), 32'h0001_0000, "select_readback");

    // Wrap from all-ones, overflow and interrupt, then write-1-to-clear
    wr(ca(0, 0), 32'hFFFE_FF00);
    wr(G_IRQ, 32'h1);
    wr(ca(0, 1), 32'hFFFF_FFFF);
    wr(ca(0, 2), 32'h0000_FFFF);
    idle(1, 4'b0001);
    rd_c(ca(0, 1), 32'h0, "wrap_lo");
    rd_c(G_OVF, 32'h1, "wrap_ovf");
    rd_c(ca(0, 2), 32'h0, "wrap_hi");
    #1 check("irq_after_ovf", 32'(perf_irq), 32'h1);
    wr(G_OVF, 32'h1);
    idle(1);
    #1 check("irq_after_w1c", 32'(perf_irq), 32'h0);

    // Shadow: HI returns upper bits latched at the LO read
    wr(ca(0, 0), 32'h0);
    wr(ca(0, 1), 32'hFFFF_FFFF);
    wr(ca(0, 2), 32'h0);
    rd_c(ca(0, 1), 32'hFFFF_FFFF, "shadow_lo");
    idle(1, 4'b0001);
    rd_c(ca(0, 2), 32'h0, "shadow_hi_stale");
    rd_c(ca(0, 1), 32'h0, "shadow_lo_live");
    rd_c(ca(0, 2), 32'h1, "shadow_hi_new");

    // Write beats a coincident event; out-of-range index never counts
    cycle(1'b1, 1'b0, ca(0, 1), 32'h0000_1234, 4'b0001);
    rd_c(ca(0, 1), 32'h0000_1234, "write_wins");
    wr(ca(0, 0), 32'(NE));
    idle(5, 4'b1111);
    rd_c(ca(0, 1), 32'h0000_1234, "index_ne_holds");
    wr(ca(0, 0), 32'h0001_00C8);
    idle(2, 4'b1111); idle(2, 4'b0000); idle(2, 4'b1111);
    rd_c(ca(0, 1), 32'h0000_1234, "edge_index200_holds");

    // Simultaneous read and write returns the old value
    cycle(1'b1, 1'b1, G_EN, 32'hF, '0, 1'b1, 32'h1, "rw_same_old");
    rd_c(G_EN, 32'hF, "rw_same_new");

    // Unmapped and out-of-block accesses
    wr(ca(5, 1), 32'h0000_AAAA);
    rd_c(ca(5, 1), 32'h0, "unmapped_counter");
    rd_c(BASE + 32'h40C, 32'h0, "unmapped_global");
    rd_c(ca(0, 3), 32'h0, "reserved_word");
    wr(BASE + 32'h1004, 32'hDEAD);
    rd_c(ca(0, 1), 32'h0000_1234, "out_of_block_write");
    rd_c(BASE + 32'h1004, 32'h0, "out_of_block_read");

    // Overflow set beats a same-cycle write-1-to-clear
    wr(ca(0, 0), 32'h0);
    wr(ca(0, 1), 32'hFFFF_FFFF);
    wr(ca(0, 2), 32'h0000_FFFF);
    cycle(1'b1, 1'b0, G_OVF, 32'h1, 4'b0001);
    rd_c(G_OVF, 32'h1, "set_beats_clear");
    idle(2, 4'b1111);
    #1 check("irq_before_reset", 32'(perf_irq), 32'h1);

    // Asynchronous reset mid-count with a pending register write
    @(negedge clk);
    bus.io_write_en = 1'b1; bus.io_read_en = 1'b0;
    bus.io_address = ca(1, 1); bus.io_write_data = 32'h55;
    perf_events = 4'b1111;
    #2 reset = 1'b1;
    #1;
    check("reset_async_irq", 32'(perf_irq), 32'h0);
    check("reset_async_rdata", bus.io_read_data, 32'h0);
    irq_q.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.io_write_en = 1'b0;
    perf_events = '0;
    rd_c(ca(1, 1), 32'h0, "post_reset_lo1");
    rd_c(ca(0, 0), 32'h0, "post_reset_sel0");
    rd_c(ca(0, 2), 32'h0, "post_reset_hi0");
    rd_c(G_EN, 32'h0, "post_reset_en");
    rd_c(G_OVF, 32'h0, "post_reset_ovf");
    rd_c(G_IRQ, 32'h0, "post_reset_irqen");

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a, d;
      int          r;
      bit          we, re;
      r = $urandom_range(0, 29);
      d = $urandom;
      if (r < 24) begin
        a = ca(r / 4, r % 4);
        if (r % 4 == 0) d = (d & 32'hFFFF_FF00) | 32'($urandom_range(0, 5));
        if (r % 4 == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | (d & 32'hF);
        if (r % 4 == 2 && $urandom_range(0, 1) == 1) d = 32'h0000_FFFF;
      end else if (r < 28) begin
        a = BASE + 32'h400 + 32'((r - 24) * 4);
      end else if (r == 28) begin
        a = BASE + 32'h1000 + 32'($urandom_range(0, 3) * 4);
      end else begin
        a = BASE - 32'h10;
      end
      we = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 2) == 0);
      cycle(we, re, a, d, NE'($urandom));
    end
    idle(3);
    check("rd_q_drained", 32'(rd_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
